// File: rtl/cpu_pkg.sv
// Shared CPU-side types and constants for the OAM DMA path.
package cpu_pkg;

  typedef enum logic [1:0] {
    DmaIdle,
    DmaSetup,
    DmaActive
  } dma_state_e;

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;

  // E0-FF sources alias the C000-DFFF work RAM through echo space.
  function automatic logic [7:0] dma_src_eff(input logic [7:0] src);
    return (src >= 8'hE0) ? src - 8'h20 : src;
  endfunction

endpackage

// File: rtl/oam_dma_bus_arbiter_if.sv
// CPU, low bus, high bus and OAM signals around the DMA arbiter.
interface oam_dma_bus_arbiter_if;
  logic [1:0]  t_cycle;
  logic        cpu_mem_enable;
  logic        cpu_mem_write;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_out;
  logic [7:0]  cpu_data_in;
  logic        bus_enable;
  logic        bus_write;
  logic [15:0] bus_addr;
  logic [7:0]  bus_data_out;
  logic [7:0]  bus_data_in;
  logic        hi_enable;
  logic        hi_write;
  logic [7:0]  hi_addr;
  logic [7:0]  hi_data_out;
  logic [7:0]  hi_data_in;
  logic        oam_write;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_data;
  logic        dma_active;

  modport master (
    input  t_cycle, cpu_mem_enable, cpu_mem_write,
    input  cpu_addr, cpu_data_out,
    input  bus_data_in, hi_data_in,
    output cpu_data_in,
    output bus_enable, bus_write, bus_addr, bus_data_out,
    output hi_enable, hi_write, hi_addr, hi_data_out,
    output oam_write, oam_addr, oam_data, dma_active
  );

  modport slave (
    output t_cycle, cpu_mem_enable, cpu_mem_write,
    output cpu_addr, cpu_data_out,
    output bus_data_in, hi_data_in,
    input  cpu_data_in,
    input  bus_enable, bus_write, bus_addr, bus_data_out,
    input  hi_enable, hi_write, hi_addr, hi_data_out,
    input  oam_write, oam_addr, oam_data, dma_active
  );
endinterface

// File: rtl/oam_dma_engine.sv
// OAM DMA sequencer: source register, byte counter and OAM write port.
module oam_dma_engine
  import cpu_pkg::*;
#(
  parameter int DMA_LENGTH = 160
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  t_cycle,
  input  logic        reg_write,
  input  logic [7:0]  reg_data,
  input  logic [7:0]  bus_data_in,
  output logic        dma_own,
  output logic [15:0] dma_addr,
  output logic        dma_active,
  output logic [7:0]  source,
  output logic        oam_write,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_data
);

  localparam logic [7:0] LAST = 8'(DMA_LENGTH - 1);

  dma_state_e state;
  logic [7:0] counter;
  logic       boundary;

  assign boundary = (t_cycle == 2'd3);

  // A restart keeps dma_active as-is so an owned bus stays blocked.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= DmaIdle;
      counter    <= 8'h00;
      source     <= 8'h00;
      dma_active <= 1'b0;
    end else if (boundary) begin
      if (reg_write) begin
        state   <= DmaSetup;
        counter <= 8'h00;
        source  <= reg_data;
      end else begin
        unique case (state)
          DmaSetup: begin
            state      <= DmaActive;
            counter    <= 8'h00;
            dma_active <= 1'b1;
          end
          DmaActive: begin
            if (counter == LAST) begin
              state      <= DmaIdle;
              counter    <= 8'h00;
              dma_active <= 1'b0;
            end else begin
              counter <= counter + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign dma_own   = (state == DmaActive);
  assign dma_addr  = dma_own ? {dma_src_eff(source), counter} : 16'h0000;
  assign oam_write = dma_own && boundary && !reset;
  assign oam_addr  = dma_own ? counter : 8'h00;
  assign oam_data  = dma_own ? bus_data_in : 8'h00;

endmodule

// File: rtl/oam_dma_bus_arbiter.sv
// CPU bus arbiter: routes CPU accesses to low/high bus, defers to OAM DMA.
module oam_dma_bus_arbiter
  import cpu_pkg::*;
#(
  parameter int         DMA_LENGTH         = 160,
  parameter logic [7:0] BLOCKED_READ_VALUE = 8'hFF
) (
  input logic                  clk,
  input logic                  reset,
  oam_dma_bus_arbiter_if.master io
);

  logic        is_low;
  logic        is_reg;
  logic        is_hi;
  logic        reg_write;
  logic        cpu_low;
  logic        hi_sel;
  logic        dma_own;
  logic [15:0] dma_addr;
  logic [7:0]  source;

  assign is_low    = (io.cpu_addr[15:8] != 8'hFF);
  assign is_reg    = (io.cpu_addr == DMA_REG_ADDR);
  assign is_hi     = !is_low && !is_reg;
  assign reg_write = io.cpu_mem_enable && io.cpu_mem_write && is_reg;
  assign cpu_low   = io.cpu_mem_enable && is_low && !io.dma_active;
  assign hi_sel    = io.cpu_mem_enable && is_hi;

  oam_dma_engine #(
    .DMA_LENGTH(DMA_LENGTH)
  ) u_engine (
    .clk        (clk),
    .reset      (reset),
    .t_cycle    (io.t_cycle),
    .reg_write  (reg_write),
    .reg_data   (io.cpu_data_out),
    .bus_data_in(io.bus_data_in),
    .dma_own    (dma_own),
    .dma_addr   (dma_addr),
    .dma_active (io.dma_active),
    .source     (source),
    .oam_write  (io.oam_write),
    .oam_addr   (io.oam_addr),
    .oam_data   (io.oam_data)
  );

  always_comb begin
    io.bus_enable   = 1'b0;
    io.bus_write    = 1'b0;
    io.bus_addr     = 16'h0000;
    io.bus_data_out = 8'h00;
    io.hi_enable    = 1'b0;
    io.hi_write     = 1'b0;
    io.hi_addr      = 8'h00;
    io.hi_data_out  = 8'h00;
    io.cpu_data_in  = BLOCKED_READ_VALUE;
    if (dma_own) begin
      io.bus_enable = 1'b1;
      io.bus_addr   = dma_addr;
    end else if (cpu_low) begin
      io.bus_enable = 1'b1;
      io.bus_write  = io.cpu_mem_write;
      io.bus_addr   = io.cpu_addr;
      if (io.cpu_mem_write)
        io.bus_data_out = io.cpu_data_out;
    end
    if (hi_sel) begin
      io.hi_enable = 1'b1;
      io.hi_write  = io.cpu_mem_write;
      io.hi_addr   = io.cpu_addr[7:0];
      if (io.cpu_mem_write)
        io.hi_data_out = io.cpu_data_out;
    end
    if (io.cpu_mem_enable && !io.cpu_mem_write) begin
      unique case (1'b1)
        is_reg:  io.cpu_data_in = source;
        is_hi:   io.cpu_data_in = io.hi_data_in;
        cpu_low: io.cpu_data_in = io.bus_data_in;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_oam_dma_bus_arbiter.sv
// Randomized bench for oam_dma_bus_arbiter against an M-cycle timeline model.
module tb_oam_dma_bus_arbiter;
  import cpu_pkg::*;

  localparam int DMA_LEN = 160;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  oam_dma_bus_arbiter_if io();

  oam_dma_bus_arbiter dut (
    .clk  (clk),
    .reset(reset),
    .io   (io)
  );

  logic [7:0] mem [0:65535];
  logic [7:0] hram [0:255];
  logic [7:0] oam [0:159];
  logic [7:0] oam_exp [0:159];

  assign io.bus_data_in = mem[io.bus_addr];
  assign io.hi_data_in  = hram[io.hi_addr];

  always @(posedge clk)
    if (io.oam_write && io.oam_addr < 8'd160)
      oam[io.oam_addr] <= io.oam_data;

  int checks = 0;
  int errors = 0;

  // Model: M-cycles since the last FF46 write (1 = Setup, 2..161 = Active).
  int         since = 1000;
  logic       owned = 1'b0;
  logic [7:0] src   = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic mcyc(input logic en, input logic wr,
                      input logic [15:0] a, input logic [7:0] d);
    logic       setup, active, da, low, isreg, ishi, cl;
    logic [7:0] cnt, se, rd;
    logic [15:0] dsrc;
    io.cpu_mem_enable = en;
    io.cpu_mem_write  = wr;
    io.cpu_addr       = a;
    io.cpu_data_out   = d;
    setup  = (since == 1);
    active = (since >= 2) && (since <= DMA_LEN + 1);
    cnt    = 8'(since - 2);
    da     = active || (setup && owned);
    se     = (src >= 8'hE0) ? src - 8'h20 : src;
    dsrc   = {se, cnt};
    low    = (a[15:8] != 8'hFF);
    isreg  = (a == 16'hFF46);
    ishi   = !low && !isreg;
    cl     = en && low && !da;
    if (!en || wr)   rd = 8'hFF;
    else if (isreg)  rd = src;
    else if (ishi)   rd = hram[a[7:0]];
    else if (da)     rd = 8'hFF;
    else             rd = mem[a];
    for (int t = 0; t < 4; t++) begin
      io.t_cycle = 2'(t);
      @(negedge clk);
      chk("dma_active", 32'(io.dma_active), 32'(da));
      chk("bus_enable", 32'(io.bus_enable), 32'(active || cl));
      chk("bus_write", 32'(io.bus_write), 32'(!active && cl && wr));
      chk("bus_addr", 32'(io.bus_addr),
          active ? 32'(dsrc) : (cl ? 32'(a) : 32'd0));
      chk("bus_data_out", 32'(io.bus_data_out),
          (!active && cl && wr) ? 32'(d) : 32'd0);
      chk("oam_write", 32'(io.oam_write), 32'(active && t == 3));
      chk("oam_addr", 32'(io.oam_addr), active ? 32'(cnt) : 32'd0);
      chk("oam_data", 32'(io.oam_data),
          active ? 32'(mem[dsrc]) : 32'd0);
      chk("hi_enable", 32'(io.hi_enable), 32'(en && ishi));
      chk("hi_write", 32'(io.hi_write), 32'(en && ishi && wr));
      chk("hi_addr", 32'(io.hi_addr), (en && ishi) ? 32'(a[7:0]) : 32'd0);
      chk("hi_data_out", 32'(io.hi_data_out),
          (en && ishi && wr) ? 32'(d) : 32'd0);
      chk("cpu_data_in", 32'(io.cpu_data_in), 32'(rd));
      @(posedge clk);
      #1;
    end
    if (active) oam_exp[cnt] = mem[dsrc];
    if (en && wr && isreg) begin
      owned = da;
      src   = d;
      since = 1;
    end else if (since < 1000) begin
      since++;
    end
  endtask

  task automatic do_reset();
    io.cpu_mem_enable = 1'b0;
    io.cpu_mem_write  = 1'b0;
    io.cpu_addr       = 16'h0000;
    io.cpu_data_out   = 8'h00;
    io.t_cycle        = 2'd3;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_oam_write", 32'(io.oam_write), 32'd0);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    since   = 1000;
    owned   = 1'b0;
    src     = 8'h00;
    io.t_cycle = 2'd0;
    @(negedge clk);
    chk("rst_dma_active", 32'(io.dma_active), 32'd0);
    chk("rst_oam_write2", 32'(io.oam_write), 32'd0);
    chk("rst_oam_addr", 32'(io.oam_addr), 32'd0);
    chk("rst_bus_enable", 32'(io.bus_enable), 32'd0);
    chk("rst_bus_addr", 32'(io.bus_addr), 32'd0);
    chk("rst_hi_enable", 32'(io.hi_enable), 32'd0);
    chk("rst_cpu_data_in", 32'(io.cpu_data_in), 32'hFF);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_op(input bit allow_restart);
    int          k;
    logic [15:0] a;
    logic [7:0]  d;
    k = $urandom_range(0, 9);
    a = 16'($urandom);
    d = 8'($urandom);
    case (k)
      0: mcyc(1'b0, 1'b0, 16'h0000, 8'h00);
      1: mcyc(1'b1, 1'b0, 16'hC000, 8'h00);
      2: mcyc(1'b1, 1'b0, a, 8'h00);
      3: mcyc(1'b1, 1'b1, 16'h8000, d);
      4: mcyc(1'b1, 1'b0, 16'hFF85, 8'h00);
      5: begin
        a[15:8] = 8'hFF;
        if (a == 16'hFF46) a = 16'hFF47;
        mcyc(1'b1, 1'b1, a, d);
      end
      6: mcyc(1'b1, 1'b0, 16'hFF46, 8'h00);
      7: begin
        if (a == 16'hFF46) a = 16'hFF45;
        mcyc(1'b1, 1'b1, a, d);
      end
      8: begin
        if (allow_restart && $urandom_range(0, 5) == 0)
          mcyc(1'b1, 1'b1, 16'hFF46, d);
        else
          mcyc(1'b1, 1'b0, a, 8'h00);
      end
      default: mcyc(1'b1, 1'b0, {8'hFF, d}, 8'h00);
    endcase
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) hram[i] = 8'($urandom);
    for (int i = 0; i < 160; i++) begin
      oam[i]     = 8'h00;
      oam_exp[i] = 8'h00;
    end
    io.t_cycle        = 2'd0;
    io.cpu_mem_enable = 1'b0;
    io.cpu_mem_write  = 1'b0;
    io.cpu_addr       = 16'h0000;
    io.cpu_data_out   = 8'h00;

    do_reset();
    mcyc(1'b1, 1'b0, 16'hFF46, 8'h00);

    // Plain transfer from C100 with random CPU traffic.
    mcyc(1'b1, 1'b1, 16'hFF46, 8'hC1);
    repeat (DMA_LEN + 1) rand_op(1'b0);
    repeat (2) mcyc(1'b0, 1'b0, 16'h0000, 8'h00);
    for (int i = 0; i < 160; i++) begin
      logic [15:0] sa;
      sa = 16'hC100 + 16'(i);
      chk("oam_c1", 32'(oam[i]), 32'(mem[sa]));
    end

    // Echo source FE reads DE00..DE9F.
    mcyc(1'b1, 1'b1, 16'hFF46, 8'hFE);
    repeat (DMA_LEN + 3) rand_op(1'b0);

    // Restart at counter 50.
    mcyc(1'b1, 1'b1, 16'hFF46, 8'hC1);
    repeat (51) rand_op(1'b0);
    mcyc(1'b1, 1'b1, 16'hFF46, 8'hC2);
    repeat (DMA_LEN + 3) rand_op(1'b0);
    for (int i = 0; i < 160; i++) begin
      logic [15:0] sa;
      sa = 16'hC200 + 16'(i);
      chk("oam_c2", 32'(oam[i]), 32'(mem[sa]));
    end

    // Reset at counter 80.
    mcyc(1'b1, 1'b1, 16'hFF46, 8'hC3);
    repeat (81) rand_op(1'b0);
    do_reset();
    mcyc(1'b0, 1'b0, 16'h0000, 8'h00);
    mcyc(1'b1, 1'b0, 16'hFF46, 8'h00);

    // Low-bus write idle vs during transfer.
    mcyc(1'b1, 1'b1, 16'h8000, 8'h5A);
    mcyc(1'b1, 1'b1, 16'hFF46, 8'h90);
    repeat (5) mcyc(1'b0, 1'b0, 16'h0000, 8'h00);
    mcyc(1'b1, 1'b1, 16'h8000, 8'hA5);

    repeat (400) rand_op(1'b1);
    repeat (DMA_LEN + 3) mcyc(1'b0, 1'b0, 16'h0000, 8'h00);
    for (int i = 0; i < 160; i++)
      chk("oam_final", 32'(oam[i]), 32'(oam_exp[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/oam_dma_bus_arbiter.md
Name: oam_dma_bus_arbiter

Overview:
- Owns the CPU's external memory bus and sequences OAM DMA transfers.
- Decodes CPU writes to the DMA register (FF46) and copies DMA_LENGTH bytes from (source<<8) into OAM, one byte per M-cycle.
- While DMA owns the bus, blocks CPU access to 0000–FEFF. FF00–FFFF (I/O, HRAM) always stays with the CPU.
- Sits between cpu_control's datapath memory signals and the memory map / PPU.

Parameters:
- DMA_LENGTH, 160, bytes per transfer; the counter is 8 bits.
- DMA_REG_ADDR, 16'hFF46, DMA start/source register address.
- BLOCKED_READ_VALUE, 8'hFF, data returned to blocked CPU reads.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- t_cycle  in  2  T-cycle within M-cycle; M-cycle boundary at t_cycle==3
- cpu_mem_enable  in  1  CPU access request this M-cycle
- cpu_mem_write  in  1  CPU write (if enable)
- cpu_addr  in  16  CPU address
- cpu_data_out  in  8  CPU write data
- cpu_data_in  out  8  read data to CPU
- bus_enable  out  1  low bus (0000–FEFF) access
- bus_write  out  1  low bus write
- bus_addr  out  16  low bus address
- bus_data_out  out  8  low bus write data
- bus_data_in  in  8  low bus read data
- hi_enable  out  1  high bus (FF00–FFFF, excluding FF46) access
- hi_write  out  1  high bus write
- hi_addr  out  8  high bus address low byte
- hi_data_out  out  8  high bus write data
- hi_data_in  in  8  high bus read data
- oam_write  out  1  OAM write strobe
- oam_addr  out  8  OAM byte index
- oam_data  out  8  OAM write data
- dma_active  out  1  DMA owns low bus

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous and active-high. All state updates happen at t_cycle==3, except reset, which applies on any edge.
- Reset values:
  - State Idle, counter 0, source register 8'h00.
  - All enables/strobes 0, dma_active 0.
  - Addresses 0, cpu_data_in 8'hFF.
- States:
  - Idle: no transfer.
  - Setup: one M-cycle; the bus is not yet owned, unless restarting.
  - Active: DMA owns the bus for DMA_LENGTH M-cycles.
- Register write: a CPU write to DMA_REG_ADDR in any state latches cpu_data_out into the source register at t_cycle==3 and moves to Setup.
  - It drives neither bus.
  - Reads of DMA_REG_ADDR return the source register combinationally.
- Setup -> Active (counter=0) at the next boundary.
- Active, each M-cycle:
  - bus_enable=1, bus_write=0.
  - bus_addr = {src_eff, counter}, where src_eff = source if source<8'hE0, else source-8'h20 (echo of C000–DFFF).
  - At t_cycle==3: oam_write=1, oam_addr=counter, oam_data=bus_data_in; then counter increments.
- Completion: after the write with counter==DMA_LENGTH-1, go to Idle. Total 1 write M-cycle + 1 Setup + DMA_LENGTH Active.
- Restart: a FF46 write during Active or Setup reloads the source, clears the counter and enters Setup.
  - If the bus was owned (Active), dma_active remains 1 through Setup with bus_enable=0 and CPU low-bus accesses still blocked.
  - A restart from Idle-originated Setup does not block.
- dma_active: 1 in Active and in restart-Setup.
- CPU routing, combinational:
  - Addresses FF00–FFFF (except FF46) go to hi_* in every state.
  - 0000–FEFF go to bus_* when dma_active=0.
  - When dma_active=1: writes are dropped and reads return BLOCKED_READ_VALUE.
  - cpu_data_in is muxed from the source of the current access.
- oam_write is asserted only at t_cycle==3 of Active cycles. oam_addr/oam_data are held stable for the whole Active M-cycle.
- Reset mid-transfer aborts immediately: no further OAM writes, counter 0.

Decomposition:
- Shared package cpu_pkg: dma_state_e {DmaIdle, DmaSetup, DmaActive} and DMA_REG_ADDR constant.
- Optional sub-module oam_dma_engine (state, counter, source, OAM port).
- The arbiter top keeps only the address decode and muxing.

Test Plan:
- Write 8'hC1 to FF46 -> 1 Setup M-cycle, then 160 Active cycles reading C100..C19F. OAM[i]=mem[C100+i]; dma_active falls after the 160th.
- CPU reads 0xC000 during Active -> cpu_data_in=8'hFF, bus_addr stays DMA's. CPU read of FF85 -> hi_enable=1, returns HRAM data.
- Write 8'hFE to FF46 -> bus_addr sequence DE00..DE9F.
- Restart with 8'hC2 at counter=50 -> one Setup cycle with dma_active=1, bus_enable=0, then OAM[0..159] from C200; OAM[50..] not written from C132+.
- Assert reset at counter=80 -> oam_write=0 next cycle, state Idle, dma_active=0. FF46 then reads 8'h00.
- CPU write to 8000 while Idle -> bus_write=1, bus_addr=8000. The same write during Active -> bus_write=0, no OAM side effect.
